// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating sum of N_TERMS multiplier products with valid/ready in and out
// Two-state machine: ACCUM takes one term per handshake, DONE holds the total until the downstream takes it.
module product_accumulator #(
  parameter int ACC_W   = 8,
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [3:0]       p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             sat,
  output logic [CNT_W-1:0] term_count
);

  localparam int SW = ACC_W + 1;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t         state, state_n;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_wide;
  logic             accept, unload, last_term;

  assign sum_out = acc;

  always_comb begin
    state_n   = state;
    p_ready   = (state == ACCUM) && !clear;
    sum_valid = (state == DONE);
    accept    = p_valid && p_ready;
    unload    = sum_valid && sum_ready && !clear;
    last_term = (term_count == CNT_W'(N_TERMS - 1));
    // one extra bit so the carry out of the add flags saturation
    sum_wide  = {1'b0, acc} + SW'(p_in);
    if (clear) begin
      state_n = ACCUM;
    end else if (accept && last_term) begin
      state_n = DONE;
    end else if (unload) begin
      state_n = ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      sat        <= 1'b0;
      term_count <= '0;
    end else if (clear || unload) begin
      acc        <= '0;
      sat        <= 1'b0;
      term_count <= '0;
    end else if (accept) begin
      acc        <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
      sat        <= sat | sum_wide[ACC_W];
      term_count <= term_count + CNT_W'(1);
    end
  end

endmodule
